// File: rtl/ysyx_24100005_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// ysyx_24100005_pkg : shared constants and types for the fetch-path memories
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
package ysyx_24100005_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } isram_state_e;

   // Unsigned 32-bit offset; addresses below the base wrap to huge values.
   function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return addr - base;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24100005_isram_array.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// ysyx_24100005_isram_array : 1R1W synchronous 32-bit word array, no reset
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module ysyx_24100005_isram_array #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [31:0]           wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
   logic [31:0] rdata_q;

   // Read samples the pre-write contents, so a colliding write is not seen.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_24100005_isram.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// ysyx_24100005_isram : fixed-latency instruction memory with preload port
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module ysyx_24100005_isram
   import ysyx_24100005_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE  = RESET_PC,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   isram_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         err_q, err_d;

   logic [31:0]  rd_off;
   logic [31:0]  wr_off;
   logic         rd_bad;
   logic         wr_bad;
   logic         accept;
   logic [31:0]  rdata;

   assign rd_off = byte_offset(req_addr, ADDR_BASE);
   assign wr_off = byte_offset(wr_addr, ADDR_BASE);
   assign rd_bad = (req_addr[1:0] != 2'b00) || ((rd_off >> (DEPTH_LOG2 + 2)) != 32'd0);
   assign wr_bad = (wr_addr[1:0]  != 2'b00) || ((wr_off >> (DEPTH_LOG2 + 2)) != 32'd0);

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   ysyx_24100005_isram_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .we_i    (wr_en && !wr_bad),
      .waddr_i (wr_off[DEPTH_LOG2+1:2]),
      .wdata_i (wr_data),
      .re_i    (accept && !rd_bad),
      .raddr_i (rd_off[DEPTH_LOG2+1:2]),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               err_d   = rd_bad;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode from state so reset clears them the instant rst rises.
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_inst  = (resp_valid && !err_q) ? rdata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: doc/ysyx_24100005_isram.md
# ysyx_24100005_isram

Instruction-memory responder for the single-cycle core's fetch path. It accepts a fetch request carrying the PC, looks up a word-addressed instruction array, and returns the 32-bit instruction after a fixed, parameterized latency over a valid/ready response channel. A side write port lets the loader or testbench preload program images. Misaligned or out-of-range addresses return an error instead of data.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte address of word 0; matches the core's PC reset value.
- `DEPTH_LOG2`, default 12: array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 1: cycles from request accept to response valid; legal range 1..15.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `req_valid` input, 1 bit: fetch request present.
- `req_ready` output, 1 bit: block can accept a request.
- `req_addr` input, 32 bits: byte address (PC).
- `resp_valid` output, 1 bit: response present.
- `resp_ready` input, 1 bit: consumer takes the response.
- `resp_inst` output, 32 bits: fetched instruction.
- `resp_err` output, 1 bit: the address was misaligned or out of range.
- `wr_en` input, 1 bit: preload write strobe.
- `wr_addr` input, 32 bits: preload byte address; uses the same base and range rules as `req_addr`.
- `wr_data` input, 32 bits: preload word.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` (accept edge):
    - Capture `rdata` = mem[idx] and `err`.
    - Load `cnt` = LATENCY-1.
    - Go to RESP if LATENCY==1, else WAIT.
- **WAIT**
  - `req_ready`=0. Decrement `cnt` each cycle.
  - When `cnt`==1 at an edge, go to RESP.
- **RESP**
  - `resp_valid`=1; `resp_inst`/`resp_err` hold the captured values, stable until handshake.
  - On `resp_ready`, go to IDLE.
  - `req_ready`=0 in RESP. There is no same-cycle new accept.
- **Index and error**
  - idx = (addr - ADDR_BASE) >> 2, width DEPTH_LOG2. The subtraction is 32-bit unsigned.
  - err = (addr[1:0]!=0) || ((addr - ADDR_BASE) >> 2) >= 2^DEPTH_LOG2. Addresses below the base wrap to large values and therefore flag an error.
  - When err=1, `resp_inst`=32'h0000_0000 and the array is not read.
- **Write port**
  - Writes are accepted in any state.
  - If the write address is misaligned or out of range, the write is silently dropped.
  - A write and a fetch accept to the same word on the same edge: the response returns the OLD data.
  - A write during WAIT/RESP does not alter an already captured response.
- The array is uninitialized. Contents are not cleared by reset.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, `cnt`=0.
  - `resp_valid`=0, `resp_inst`=0, `resp_err`=0.
  - `req_ready` is forced to 0 while `rst`=1.
- Reset mid-operation discards the pending fetch. No response is ever emitted for it.
- Latency: a request accepted on edge T gives `resp_valid`=1 during the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after accept.
- Throughput: one fetch per LATENCY+1 cycles when `resp_ready` is held high.
- Backpressure: `resp_ready`=0 holds RESP indefinitely, with all outputs stable.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `resp_*`.

## Structure
- Shared package `ysyx_24100005_pkg`:
  - `RESET_PC` constant (32'h8000_0000), reused as the `ADDR_BASE` default.
  - The state enum encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- One natural sub-module: `ysyx_24100005_isram_array`, a 1R1W synchronous word array that reads on the accept edge and writes on `wr_en`.
- FSM, counter and address checking stay in the top of this block.

## Test plan
- **Preload and fetch**, LATENCY=1: write 32'h0010_0093 at 32'h8000_0000, then request 32'h8000_0000. Required: `resp_valid` exactly one cycle after accept, `resp_inst`=32'h0010_0093, `resp_err`=0.
- **Latency and backpressure**, LATENCY=3: request 32'h8000_0004 with `resp_ready`=0 for 5 cycles. Required: `resp_valid` rises 3 cycles after accept, outputs stay stable, `req_ready`=0 throughout, IDLE is entered the cycle after `resp_ready`=1.
- **Errors**: request 32'h8000_0002, then 32'h7FFF_FFFC, then 32'h8000_4000 with DEPTH_LOG2=12. Required: each returns `resp_err`=1 and `resp_inst`=0.
- **Write/fetch collision**: mem[1]=A. On the same edge, write B to 32'h8000_0004 and accept a fetch of 32'h8000_0004. Required: the response is A; the next fetch of the same address returns B.
- **Reset mid-fetch**, LATENCY=4: assert `rst` 2 cycles after accept. Required: `resp_valid`, `resp_inst` and `resp_err` go to 0 immediately, `req_ready`=0 while `rst`=1, and no response appears after release.
- **Streaming**, LATENCY=2 with `resp_ready` held at 1: issue 8 sequential PCs from 32'h8000_0000. Required: in-order correct data with one accept every 3 cycles.
